// File: rtl/tcdm_stream_pkg.sv
// Shared types for the TCDM stream reader.
// Contents:
//   state_e  - transfer FSM state encoding
//   AMO_NONE - atomic opcode meaning "plain access"
package tcdm_stream_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [3:0] AMO_NONE = 4'h0;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the response buffer of the stream reader.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, data_i     - write side; ignored when full unless a pop frees a slot
//   pop_i, data_o      - read side; data_o is the head entry, pop ignored when empty
//   empty_o, usage_o   - status: empty flag and current occupancy
module fifo_v3 #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4,
  localparam int unsigned AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 empty_o,
  output logic [AddrW:0]       usage_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]       cnt_q, cnt_d;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt_q == (AddrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AddrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AddrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM reader that turns a (base, stride, len) job into a stream of words.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   cfg_*_i, start_i        - job description, latched on start in idle
//   busy_o, done_o          - job active, one-cycle completion pulse
//   tcdm_req_*_o            - read-only TCDM request channel
//   tcdm_rsp_*_i            - request accept and in-order response channel
//   stream_*                - valid/ready element stream out of the response buffer
// Requests are throttled by a credit count so that every outstanding read
// always has a free buffer slot waiting for it.
module tcdm_stream_reader
  import tcdm_stream_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned TCDMAddrWidth   = 17,
  parameter int unsigned BufDepth        = 4,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [TCDMAddrWidth-1:0]     cfg_base_i,
  input  logic [TCDMAddrWidth-1:0]     cfg_stride_i,
  input  logic [CntWidth-1:0]          cfg_len_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         tcdm_req_write_o,
  output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
  output logic [3:0]                   tcdm_req_amo_o,
  output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
  output logic [4:0]                   tcdm_req_user_core_id_o,
  output logic                         tcdm_req_user_is_core_o,
  output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
  output logic                         tcdm_req_q_valid_o,
  input  logic                         tcdm_rsp_q_ready_i,
  input  logic                         tcdm_rsp_p_valid_i,
  input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
  output logic [NarrowDataWidth-1:0]   stream_data_o,
  output logic                         stream_valid_o,
  input  logic                         stream_ready_i
);

  localparam int unsigned OutW = $clog2(BufDepth) + 1;

  state_e                     state_q, state_d;
  logic [TCDMAddrWidth-1:0]   addr_q, addr_d;
  logic [TCDMAddrWidth-1:0]   stride_q, stride_d;
  logic [CntWidth-1:0]        len_q, len_d;
  logic [CntWidth-1:0]        idx_q, idx_d;
  logic [CntWidth-1:0]        pop_cnt_q, pop_cnt_d;
  logic [OutW-1:0]            outst_q, outst_d;
  logic                       done_q, done_d;

  logic [OutW-1:0]            buf_usage;
  logic                       buf_empty;
  logic [NarrowDataWidth-1:0] buf_head;
  logic                       credit_ok;
  logic                       req_valid;
  logic                       req_hs;
  logic                       rsp_push;
  logic                       stream_pop;

  // Credits only grow while a request waits (responses move a credit from
  // outstanding to occupancy, pops free one), so q_valid cannot drop unaccepted.
  assign credit_ok  = (32'(outst_q) + 32'(buf_usage)) < BufDepth;
  assign req_valid  = (state_q == StIssue) && credit_ok;
  assign req_hs     = req_valid && tcdm_rsp_q_ready_i;
  // Responses without a matching request (e.g. after a reset abort) are dropped.
  assign rsp_push   = tcdm_rsp_p_valid_i && (outst_q != '0);
  assign stream_pop = !buf_empty && stream_ready_i;

  fifo_v3 #(
    .DataWidth (NarrowDataWidth),
    .Depth     (BufDepth)
  ) i_rsp_buf (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .push_i  (rsp_push),
    .data_i  (tcdm_rsp_data_i),
    .pop_i   (stream_pop),
    .data_o  (buf_head),
    .empty_o (buf_empty),
    .usage_o (buf_usage)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    len_d     = len_q;
    idx_d     = idx_q;
    pop_cnt_d = pop_cnt_q;
    done_d    = 1'b0;

    if (stream_pop) begin
      pop_cnt_d = pop_cnt_q + CntWidth'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StIssue;
            addr_d    = cfg_base_i;
            stride_d  = cfg_stride_i;
            len_d     = cfg_len_i;
            idx_d     = '0;
            pop_cnt_d = '0;
          end
        end
      end
      StIssue: begin
        if (req_hs) begin
          addr_d = addr_q + stride_q;
          idx_d  = idx_q + CntWidth'(1);
          if (idx_q == len_q - CntWidth'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // The last response always lands after the last request, so the
        // final pop can only happen here.
        if (stream_pop && (pop_cnt_q == len_q - CntWidth'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    unique case ({req_hs, rsp_push})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      pop_cnt_q <= '0;
      outst_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      pop_cnt_q <= pop_cnt_d;
      outst_q   <= outst_d;
      done_q    <= done_d;
    end
  end

  assign busy_o                  = (state_q != StIdle);
  assign done_o                  = done_q;
  assign tcdm_req_write_o        = 1'b0;
  assign tcdm_req_addr_o         = addr_q;
  assign tcdm_req_amo_o          = AMO_NONE;
  assign tcdm_req_data_o         = '0;
  assign tcdm_req_user_core_id_o = '0;
  assign tcdm_req_user_is_core_o = 1'b0;
  assign tcdm_req_strb_o         = '1;
  assign tcdm_req_q_valid_o      = req_valid;
  assign stream_valid_o          = !buf_empty;
  // Masked so the data bus reads zero whenever nothing is presented.
  assign stream_data_o           = buf_empty ? '0 : buf_head;

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Self-checking bench for tcdm_stream_reader: directed scenarios plus random
// jobs, checked against a transaction-level model (address formula, response
// queue, credit bound).
module tb_tcdm_stream_reader;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 17;
  localparam int unsigned BD = 4;
  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] cfg_base_i = '0;
  logic [AW-1:0] cfg_stride_i = '0;
  logic [CW-1:0] cfg_len_i = '0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o;
  logic          tcdm_req_write_o;
  logic [AW-1:0] tcdm_req_addr_o;
  logic [3:0]    tcdm_req_amo_o;
  logic [DW-1:0] tcdm_req_data_o;
  logic [4:0]    tcdm_req_user_core_id_o;
  logic          tcdm_req_user_is_core_o;
  logic [DW/8-1:0] tcdm_req_strb_o;
  logic          tcdm_req_q_valid_o;
  logic          tcdm_rsp_q_ready_i = 1'b0;
  logic          tcdm_rsp_p_valid_i = 1'b0;
  logic [DW-1:0] tcdm_rsp_data_i = '0;
  logic [DW-1:0] stream_data_o;
  logic          stream_valid_o;
  logic          stream_ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  tcdm_stream_reader #(
    .NarrowDataWidth (DW),
    .TCDMAddrWidth   (AW),
    .BufDepth        (BD),
    .CntWidth        (CW)
  ) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .cfg_base_i              (cfg_base_i),
    .cfg_stride_i            (cfg_stride_i),
    .cfg_len_i               (cfg_len_i),
    .start_i                 (start_i),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .tcdm_req_write_o        (tcdm_req_write_o),
    .tcdm_req_addr_o         (tcdm_req_addr_o),
    .tcdm_req_amo_o          (tcdm_req_amo_o),
    .tcdm_req_data_o         (tcdm_req_data_o),
    .tcdm_req_user_core_id_o (tcdm_req_user_core_id_o),
    .tcdm_req_user_is_core_o (tcdm_req_user_is_core_o),
    .tcdm_req_strb_o         (tcdm_req_strb_o),
    .tcdm_req_q_valid_o      (tcdm_req_q_valid_o),
    .tcdm_rsp_q_ready_i      (tcdm_rsp_q_ready_i),
    .tcdm_rsp_p_valid_i      (tcdm_rsp_p_valid_i),
    .tcdm_rsp_data_i         (tcdm_rsp_data_i),
    .stream_data_o           (stream_data_o),
    .stream_valid_o          (stream_valid_o),
    .stream_ready_i          (stream_ready_i)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state
  int            pend_due[$];   // due cycle of each outstanding read, in order
  logic [DW-1:0] exp_q[$];      // words expected in the buffer, head first
  logic [AW-1:0] hs_addr[$];    // addresses accepted in the current job
  int            hs_cyc[$];
  int            last_due = 0;
  int            stale_cnt = 0;
  bit            active = 0, issuing = 0, done_exp = 0;
  logic [AW-1:0] m_base = '0, m_stride = '0;
  int unsigned   m_len = 0, m_k = 0, m_pop = 0;

  // Stimulus knobs
  int qr_mode = 0;   // 0 always ready, 1 random, 2 pattern 0,0,1
  int sr_mode = 1;   // 0 never, 1 always, 2 random
  int lat_min = 1, lat_max = 1, qr_phase = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  bit start_req = 0;
  logic [AW-1:0] s_base = '0, s_stride = '0;
  logic [CW-1:0] s_len = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit hs, pop, push, done_next, was_active;
    int due;
    logic [63:0] ea;
    @(negedge clk_i);
    chk("busy", 64'(busy_o), 64'(active));
    chk("done", 64'(done_o), 64'(done_exp));
    chk("q_valid", 64'(tcdm_req_q_valid_o),
        64'(issuing && (pend_due.size() + exp_q.size() < BD)));
    chk("s_valid", 64'(stream_valid_o), 64'(exp_q.size() != 0));
    if (prev_stall) begin
      chk("hold_valid", 64'(tcdm_req_q_valid_o), 64'd1);
      chk("hold_addr", 64'(tcdm_req_addr_o), 64'(prev_addr));
    end

    case (qr_mode)
      0: tcdm_rsp_q_ready_i = 1'b1;
      1: tcdm_rsp_q_ready_i = 1'($urandom_range(0, 1));
      default: begin
        tcdm_rsp_q_ready_i = (qr_phase == 2);
        if (tcdm_req_q_valid_o) qr_phase = (qr_phase + 1) % 3;
      end
    endcase
    case (sr_mode)
      0: stream_ready_i = 1'b0;
      1: stream_ready_i = 1'b1;
      default: stream_ready_i = 1'($urandom_range(0, 1));
    endcase
    tcdm_rsp_p_valid_i = 1'b0;
    tcdm_rsp_data_i    = {$urandom, $urandom};
    push = 0;
    if (stale_cnt > 0) begin
      tcdm_rsp_p_valid_i = 1'b1;
      stale_cnt--;
    end else if (pend_due.size() > 0 && pend_due[0] <= cycle) begin
      tcdm_rsp_p_valid_i = 1'b1;
      push = 1;
    end
    start_i = start_req;
    if (start_req) begin
      cfg_base_i = s_base; cfg_stride_i = s_stride; cfg_len_i = s_len;
    end else begin
      // Junk config outside the start cycle: the job must use latched values.
      cfg_base_i = AW'($urandom); cfg_stride_i = AW'($urandom); cfg_len_i = CW'($urandom);
    end
    start_req = 0;

    was_active = active;
    done_next  = 0;
    hs  = tcdm_req_q_valid_o && tcdm_rsp_q_ready_i;
    pop = stream_valid_o && stream_ready_i && (exp_q.size() > 0);
    if (hs) begin
      ea = (64'(m_base) + 64'(m_k) * 64'(m_stride)) % (64'd1 << AW);
      chk("addr", 64'(tcdm_req_addr_o), ea);
      chk("write", 64'(tcdm_req_write_o), 64'd0);
      chk("amo", 64'(tcdm_req_amo_o), 64'd0);
      chk("wdata", tcdm_req_data_o, 64'd0);
      chk("strb", 64'(tcdm_req_strb_o), 64'hFF);
      chk("user", {58'd0, tcdm_req_user_core_id_o, tcdm_req_user_is_core_o}, 64'd0);
      hs_addr.push_back(tcdm_req_addr_o);
      hs_cyc.push_back(cycle);
      m_k++;
      due = cycle + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      pend_due.push_back(due);
      last_due = due;
      if (m_k == m_len) issuing = 0;
    end
    if (pop) begin
      chk("data", stream_data_o, exp_q.pop_front());
      m_pop++;
      if (m_pop == m_len) begin active = 0; done_next = 1; end
    end
    if (push) begin
      void'(pend_due.pop_front());
      exp_q.push_back(tcdm_rsp_data_i);
    end
    if (start_i && !was_active) begin
      if (s_len == 0) done_next = 1;
      else begin
        active = 1; issuing = 1; m_k = 0; m_pop = 0;
        m_base = s_base; m_stride = s_stride; m_len = s_len;
        hs_addr.delete(); hs_cyc.delete();
      end
    end
    done_exp   = done_next;
    prev_stall = tcdm_req_q_valid_o && !tcdm_rsp_q_ready_i;
    prev_addr  = tcdm_req_addr_o;
    @(posedge clk_i);
    cycle++;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s, input int l);
    s_base = b; s_stride = s; s_len = CW'(l); start_req = 1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active && n < budget) begin tick(); n++; end
    chk("job_finished", 64'(active), 64'd0);
    tick();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 0; tcdm_rsp_p_valid_i = 0; tcdm_rsp_q_ready_i = 0; stream_ready_i = 0;
    #1;
    chk("rst_qvalid", 64'(tcdm_req_q_valid_o), 64'd0);
    chk("rst_svalid", 64'(stream_valid_o), 64'd0);
    chk("rst_sdata", stream_data_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(tcdm_req_addr_o), 64'd0);
    chk("rst_strb", 64'(tcdm_req_strb_o), 64'hFF);
    stale_cnt = pend_due.size();
    pend_due.delete(); exp_q.delete();
    active = 0; issuing = 0; done_exp = 0; prev_stall = 0; last_due = cycle;
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin
    int n;
    do_reset(2);

    // Stride sequence, best-case throughput
    qr_mode = 0; sr_mode = 1; lat_min = 1; lat_max = 1;
    start_job(17'h100, 17'd8, 4);
    wait_idle(60);
    chk("stride_cnt", 64'(hs_addr.size()), 64'd4);
    if (hs_addr.size() == 4) begin
      chk("stride_a0", 64'(hs_addr[0]), 64'h100);
      chk("stride_a3", 64'(hs_addr[3]), 64'h118);
      chk("stride_back2back", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    end

    // Credit stall
    sr_mode = 0;
    start_job(17'h400, 17'd4, 8);
    repeat (15) tick();
    chk("credit_issued", 64'(hs_addr.size()), 64'd4);
    sr_mode = 1;
    wait_idle(100);
    chk("credit_total", 64'(hs_addr.size()), 64'd8);

    // Backpressure stability
    qr_mode = 2; qr_phase = 0;
    start_job(17'h40, 17'd4, 3);
    wait_idle(100);
    chk("bp_cnt", 64'(hs_addr.size()), 64'd3);
    qr_mode = 0;

    // Address wrap
    start_job(17'h1FFF8, 17'd16, 3);
    wait_idle(60);
    chk("wrap_cnt", 64'(hs_addr.size()), 64'd3);
    if (hs_addr.size() == 3) begin
      chk("wrap_a0", 64'(hs_addr[0]), 64'h1FFF8);
      chk("wrap_a1", 64'(hs_addr[1]), 64'h00008);
      chk("wrap_a2", 64'(hs_addr[2]), 64'h00018);
    end

    // Zero length
    start_job(17'h800, 17'd8, 0);
    repeat (3) tick();

    // Start during drain is ignored
    sr_mode = 0;
    start_job(17'h200, 17'd8, 3);
    n = 0;
    while (issuing && n < 30) begin tick(); n++; end
    start_job(17'h300, 17'd4, 5);
    repeat (2) tick();
    sr_mode = 1;
    wait_idle(60);
    chk("late_start_cnt", 64'(hs_addr.size()), 64'd3);
    repeat (3) tick();

    // Mid-transfer reset with two responses outstanding
    lat_min = 6; lat_max = 6;
    start_job(17'h600, 17'd8, 6);
    n = 0;
    while (pend_due.size() < 2 && n < 30) begin tick(); n++; end
    chk("reset_outstanding", 64'(pend_due.size()), 64'd2);
    do_reset(2);
    repeat (4) tick();
    lat_min = 1; lat_max = 1;
    start_job(17'h500, 17'h20, 2);
    wait_idle(60);
    chk("post_reset_cnt", 64'(hs_addr.size()), 64'd2);

    // Random jobs
    qr_mode = 1; sr_mode = 2; lat_min = 1; lat_max = 4;
    repeat (10) begin
      start_job(AW'($urandom), AW'($urandom), int'($urandom_range(1, 12)));
      wait_idle(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
